adc_sar_responder: RTL
======================

// Module: adc_sar_responder
// PURPOSE
//  Converter-side end of the sc/eoc/oe start-of-conversion handshake. Receives the
//  sc start pulse, runs an N-bit successive-approximation search against an external
//  comparator through a DAC code, and raises eoc when the result is ready.
//  Drives the result onto data while oe is asserted (active-low). Sits between the
//  ADC control FSM and the analog front end (DAC plus comparator).
// PARAMETERS
//  N          8  result width / number of SAR bit trials
//  SETTLE     2  clock cycles per bit trial (DAC settle time); must be >= 1
//  SAMPLE_CYC 2  track/hold cycles before the first trial; must be >= 1
// PORTS
//  clk     in   1  single clock, rising edge
//  reset   in   1  asynchronous, active-low; clears all state
//  sc      in   1  start conversion, active-high; sampled on rising clk
//  oe      in   1  output enable, active-low; 0 drives data
//  comp    in   1  comparator: 1 when vin >= DAC voltage
//  track   out  1  1 during the SAMPLE state (front end tracks the input)
//  dac     out  N  trial code presented to the DAC
//  eoc     out  1  end of conversion; 1 only in DONE
//  data    out  N  oe==0: last completed result; oe==1: all zeros
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, track=0, eoc=0, dac=0, work=0, result=0.
//  States:
//   IDLE:    sc==1 -> SAMPLE, else stay
//   SAMPLE:  track=1 for SAMPLE_CYC cycles -> CONVERT; on entering CONVERT, bit=N-1
//            and dac = 1<<(N-1)
//   CONVERT: per bit i, from MSB to LSB:
//            - dac = work | (1<<i), held for SETTLE cycles
//            - on the last settle edge: work[i] = comp
//            - i>0 -> next bit; i==0 -> DONE, result <= final work
//   DONE:    eoc=1; sc==1 -> SAMPLE, with eoc cleared on that same edge; else stay
//  Latency: sc sampled at edge E0 -> eoc==1 after edge E0+SAMPLE_CYC+N*SETTLE
//   (defaults: 18 cycles).
//  eoc falls on the edge that accepts the next sc. It is never high in SAMPLE or
//   CONVERT.
//  sc during SAMPLE or CONVERT: ignored. A conversion always completes once started.
//  result is written only at the DONE transition. A read during a conversion returns
//   the previous result (0 after reset).
//  data is combinational from oe and result. It has no state dependency.
//  dac is registered. dac=0 in IDLE and SAMPLE; in DONE, dac holds the final code.
//  Reset mid-conversion: aborts immediately. The next start needs a new sc.
//  Undefined state encodings -> IDLE (fault recovery).
//  Cycle counter width: $clog2(max(SETTLE,SAMPLE_CYC))+1. Bit index width: $clog2(N).
// STRUCTURE
//  Shared package adc_pkg:
//   - state encodings ADC_IDLE=2'd0, ADC_SAMPLE=2'd1, ADC_CONVERT=2'd2, ADC_DONE=2'd3
//   - default ADC_N=8
//  Sub-module adc_settle_timer: loadable down-counter with a terminal-count output.
//   Used for both SAMPLE_CYC and SETTLE.
//  The FSM, SAR register and result register stay in this module.
// TESTING
//  The bench models the comparator as comp = (vin >= dac), evaluated every cycle.
//  1. vin=8'hA5; 1-cycle sc; oe=1 -> track high 2 cycles; eoc rises 18 cycles after
//     the sc edge; then oe=0 -> data==8'hA5.
//  2. vin=8'h00, then vin=8'hFF, back to back:
//     - the second sc is issued while in DONE
//     - eoc drops on that sc edge
//     - results are 8'h00, then 8'hFF
//  3. vin=8'h3C; pulse sc again at cycles 5 and 10 of CONVERT -> ignored; eoc still
//     at cycle 18; data==8'h3C.
//  4. Hold oe=0 through a new conversion (vin=8'h81) after a previous 8'h3C result:
//     - data stays 8'h3C until the DONE edge, then becomes 8'h81
//     - oe=1 -> data==0
//  5. Assert reset at cycle 9 of a conversion:
//     - eoc=0, dac=0, track=0 immediately, with no clk edge
//     - after release, data==0 and the FSM stays in IDLE until sc
//  6. SETTLE=1, SAMPLE_CYC=1, N=4, vin=4'h9 -> eoc after 5 cycles; data==4'h9.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the SAR converter responder: state encodings and
// default result width.
package adc_pkg;

  localparam int ADC_N = 8;

  typedef enum logic [1:0] {
    ADC_IDLE    = 2'd0,
    ADC_SAMPLE  = 2'd1,
    ADC_CONVERT = 2'd2,
    ADC_DONE    = 2'd3
  } adc_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adc_settle_timer.sv
// Loadable down-counter; tc is high while the count sits at zero. Times both
// the track/hold window and each DAC settle interval.
module adc_settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/adc_sar_responder.sv
// Converter side of the sc/eoc/oe handshake: samples on sc, runs an N-bit SAR
// search through the DAC/comparator, and raises eoc while the result is ready.
module adc_sar_responder
  import adc_pkg::*;
#(
  parameter int N          = ADC_N,
  parameter int SETTLE     = 2,
  parameter int SAMPLE_CYC = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sc,
  input  logic         oe,
  input  logic         comp,
  output logic         track,
  output logic [N-1:0] dac,
  output logic         eoc,
  output logic [N-1:0] data,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(max_int(SETTLE, SAMPLE_CYC)) + 1;
  localparam int BW = $clog2(N);
  localparam logic [CW-1:0] SAMPLE_LD = CW'(SAMPLE_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);
  localparam logic [N-1:0]  ONE       = N'(1);

  adc_state_e    state, state_nxt;
  logic [N-1:0]  work, work_nxt, result;
  logic [BW-1:0] bit_idx;
  logic          tmr_load, tmr_tc;
  logic [CW-1:0] tmr_val;

  adc_settle_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ADC_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = ADC_IDLE;
    case (state)
      ADC_IDLE:    state_nxt = sc ? ADC_SAMPLE : ADC_IDLE;
      ADC_SAMPLE:  state_nxt = tmr_tc ? ADC_CONVERT : ADC_SAMPLE;
      ADC_CONVERT: state_nxt = (tmr_tc && bit_idx == '0) ? ADC_DONE : ADC_CONVERT;
      ADC_DONE:    state_nxt = sc ? ADC_SAMPLE : ADC_DONE;
      default:     state_nxt = ADC_IDLE;
    endcase
  end

  always_comb begin
    track     = (state == ADC_SAMPLE);
    eoc       = (state == ADC_DONE);
    dbg_state = state;
  end

  // Timer reload points: a new start, the start of the first trial, each later trial.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = SETTLE_LD;
    if ((state == ADC_IDLE || state == ADC_DONE) && sc) begin
      tmr_load = 1'b1;
      tmr_val  = SAMPLE_LD;
    end else if (state == ADC_SAMPLE && tmr_tc) begin
      tmr_load = 1'b1;
    end else if (state == ADC_CONVERT && tmr_tc && bit_idx != '0) begin
      tmr_load = 1'b1;
    end
  end

  always_comb begin
    work_nxt          = work;
    work_nxt[bit_idx] = comp;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dac     <= '0;
      work    <= '0;
      result  <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        ADC_IDLE, ADC_DONE: begin
          if (sc) begin
            dac  <= '0;
            work <= '0;
          end
        end
        ADC_SAMPLE: begin
          if (tmr_tc) begin
            bit_idx <= BW'(N - 1);
            dac     <= ONE << (N - 1);
            work    <= '0;
          end
        end
        ADC_CONVERT: begin
          if (tmr_tc) begin
            work <= work_nxt;
            if (bit_idx == '0) begin
              result <= work_nxt;
              dac    <= work_nxt;
            end else begin
              bit_idx <= bit_idx - 1'b1;
              dac     <= work_nxt | (ONE << (bit_idx - 1'b1));
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign data = oe ? '0 : result;

endmodule
